// File: rtl/cpu_pkg.sv
// Shared CPU definitions: branch-condition encodings and default PC vectors
// used by the fetch-stage next-PC generator.
package cpu_pkg;

  typedef enum logic [2:0] {
    BR_BEQ  = 3'd0,
    BR_BNE  = 3'd1,
    BR_BLEZ = 3'd2,
    BR_BGTZ = 3'd3,
    BR_BLTZ = 3'd4,
    BR_BGEZ = 3'd5,
    BR_RSV6 = 3'd6,
    BR_RSV7 = 3'd7
  } br_op_e;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_PC   = 32'h0000_4180;

endpackage

// File: rtl/pc_gen_unit_if.sv
// Decode/exception-side bundle of the next-PC generator; the slave modport is
// the PC unit itself, the master modport is the hazard/decode logic driving it.
interface pc_gen_unit_if
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 32
);
  logic              stall_f;
  logic [ADDR_W-1:0] pc_d;
  logic              br_valid;
  br_op_e            br_op;
  logic [31:0]       rs_val;
  logic [31:0]       rt_val;
  logic [15:0]       imm16;
  logic              j_valid;
  logic [25:0]       j_index;
  logic              jr_valid;
  logic [ADDR_W-1:0] jr_target;
  logic              exc_req;
  logic              eret_req;
  logic [ADDR_W-1:0] epc;
  logic [ADDR_W-1:0] pc_f;
  logic [ADDR_W-1:0] pc4_f;
  logic              taken_d;
  logic [ADDR_W-1:0] link_d;
  logic              flush_f;
  logic              misalign_f;

  modport slave (
    input  stall_f, pc_d, br_valid, br_op, rs_val, rt_val, imm16,
           j_valid, j_index, jr_valid, jr_target, exc_req, eret_req, epc,
    output pc_f, pc4_f, taken_d, link_d, flush_f, misalign_f
  );

  modport master (
    output stall_f, pc_d, br_valid, br_op, rs_val, rt_val, imm16,
           j_valid, j_index, jr_valid, jr_target, exc_req, eret_req, epc,
    input  pc_f, pc4_f, taken_d, link_d, flush_f, misalign_f
  );
endinterface

// File: rtl/pc_gen_unit_br_cmp.sv
// Combinational branch-condition evaluator: BEQ/BNE compare rs with rt, the
// zero-compare ops treat rs as a signed two's-complement value.
module br_cmp
  import cpu_pkg::*;
(
  input  br_op_e      br_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        taken
);

  logic signed [31:0] rs_s;
  logic               rs_neg;
  logic               rs_zero;

  assign rs_s    = rs_val;
  assign rs_neg  = (rs_s < 0);
  assign rs_zero = (rs_val == 32'd0);

  always_comb begin
    taken = 1'b0;
    unique case (br_op)
      BR_BEQ:  taken = (rs_val == rt_val);
      BR_BNE:  taken = (rs_val != rt_val);
      BR_BLEZ: taken = rs_neg | rs_zero;
      BR_BGTZ: taken = ~rs_neg & ~rs_zero;
      BR_BLTZ: taken = rs_neg;
      BR_BGEZ: taken = ~rs_neg;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_gen_unit.sv
// Fetch-stage PC register with redirect priority mux and a one-entry pending
// redirect for stalls. Build option: DELAY_SLOT_EN (architected delay slot).
module pc_gen_unit
  import cpu_pkg::*;
#(
  parameter int          ADDR_W   = 32,
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] EXC_PC   = DEF_EXC_PC
) (
  input  logic        clk,
  input  logic        reset,
  pc_gen_unit_if.slave bus
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_nxt;
  logic              pend_valid;
  logic              pend_valid_nxt;
  logic [ADDR_W-1:0] pend_target;
  logic [ADDR_W-1:0] pend_target_nxt;
  logic [ADDR_W-1:0] pc4_d;
  logic [ADDR_W-1:0] br_tgt;
  logic [ADDR_W-1:0] j_tgt;
  logic [ADDR_W-1:0] dec_tgt;
  logic              br_true;
  logic              dec_redir;

  function automatic logic [ADDR_W-1:0] br_offset(input logic [15:0] imm);
    return {{(ADDR_W-18){imm[15]}}, imm, 2'b00};
  endfunction

  br_cmp u_br_cmp (
    .br_op  (bus.br_op),
    .rs_val (bus.rs_val),
    .rt_val (bus.rt_val),
    .taken  (br_true)
  );

  assign pc4_d  = bus.pc_d + ADDR_W'(32'd4);
  assign br_tgt = pc4_d + br_offset(bus.imm16);

  // Jump keeps the region bits above bit 27; a 28-bit PC has no region field.
  generate
    if (ADDR_W > 28) begin : g_jregion
      assign j_tgt = {pc4_d[ADDR_W-1:28], bus.j_index, 2'b00};
    end else begin : g_jflat
      assign j_tgt = {bus.j_index, 2'b00};
    end
  endgenerate

  assign dec_redir = bus.jr_valid | bus.j_valid | (bus.br_valid & br_true);

  always_comb begin
    dec_tgt = br_tgt;
    if (bus.jr_valid)     dec_tgt = bus.jr_target;
    else if (bus.j_valid) dec_tgt = j_tgt;
  end

  always_comb begin
    pc_nxt          = pc_q;
    pend_valid_nxt  = pend_valid;
    pend_target_nxt = pend_target;
    if (bus.exc_req) begin
      pc_nxt         = EXC_PC[ADDR_W-1:0];
      pend_valid_nxt = 1'b0;
    end else if (bus.eret_req) begin
      pc_nxt         = bus.epc;
      pend_valid_nxt = 1'b0;
    end else if (dec_redir && !bus.stall_f) begin
      pc_nxt         = dec_tgt;
      pend_valid_nxt = 1'b0;
    end else if (dec_redir) begin
      pend_valid_nxt  = 1'b1;
      pend_target_nxt = dec_tgt;
    end else if (pend_valid && !bus.stall_f) begin
      pc_nxt         = pend_target;
      pend_valid_nxt = 1'b0;
    end else if (!bus.stall_f) begin
      pc_nxt = pc_q + ADDR_W'(32'd4);
    end
  end

  // Fetch PC register boundary
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_PC[ADDR_W-1:0];
      pend_valid <= 1'b0;
    end else begin
      pc_q       <= pc_nxt;
      pend_valid <= pend_valid_nxt;
    end
  end

  always_ff @(posedge clk) begin
    pend_target <= pend_target_nxt;
  end

  assign bus.pc_f       = pc_q;
  assign bus.pc4_f      = pc_q + ADDR_W'(32'd4);
  assign bus.taken_d    = dec_redir;
  assign bus.misalign_f = (pc_q[1:0] != 2'b00);

`ifdef DELAY_SLOT_EN
  assign bus.link_d  = bus.pc_d + ADDR_W'(32'd8);
  assign bus.flush_f = bus.exc_req | bus.eret_req;
`else
  logic pend_apply;

  // A deferred redirect kills the wrong-path fetch in the cycle it lands.
  assign pend_apply  = pend_valid & ~bus.stall_f & ~bus.exc_req & ~bus.eret_req & ~dec_redir;
  assign bus.link_d  = pc4_d;
  assign bus.flush_f = (dec_redir & ~bus.stall_f) | pend_apply | bus.exc_req | bus.eret_req;
`endif

endmodule

// File: tb/tb_pc_gen_unit.sv
// Directed bench for pc_gen_unit: reset, sequential fetch, branch/jump/jr
// redirects, stall capture, exception/eret, misalignment and wrap.
`timescale 1ns/1ps
module tb_pc_gen_unit;
  import cpu_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  pc_gen_unit_if #(.ADDR_W(32)) bus ();

  pc_gen_unit #(.ADDR_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef DELAY_SLOT_EN
  localparam logic DEC_FLUSH = 1'b0;
  localparam logic [31:0] LINK_ADD = 32'd8;
`else
  localparam logic DEC_FLUSH = 1'b1;
  localparam logic [31:0] LINK_ADD = 32'd4;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_dec();
    bus.br_valid = 1'b0;
    bus.j_valid  = 1'b0;
    bus.jr_valid = 1'b0;
    bus.exc_req  = 1'b0;
    bus.eret_req = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.stall_f   = 1'b0;
    bus.pc_d      = '0;
    bus.br_op     = BR_BEQ;
    bus.rs_val    = '0;
    bus.rt_val    = '0;
    bus.imm16     = '0;
    bus.j_index   = '0;
    bus.jr_target = '0;
    bus.epc       = '0;
    clear_dec();
    #3;
    check("rst_pc", bus.pc_f, 32'h3000);
    check("rst_pc4", bus.pc4_f, 32'h3004);
    check("rst_taken", 32'(bus.taken_d), 32'd0);
    check("rst_flush", 32'(bus.flush_f), 32'd0);
    check("rst_misal", 32'(bus.misalign_f), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Sequential fetch
    step(); check("seq1", bus.pc_f, 32'h3004);
    step(); check("seq2", bus.pc_f, 32'h3008);
    step(); check("seq3", bus.pc_f, 32'h300C);

    // BEQ taken, backward offset -4 words
    bus.pc_d = 32'h3010; bus.br_valid = 1'b1; bus.br_op = BR_BEQ;
    bus.rs_val = 32'd5; bus.rt_val = 32'd5; bus.imm16 = 16'hFFFC;
    #1;
    check("beq_taken", 32'(bus.taken_d), 32'd1);
    check("beq_flush", 32'(bus.flush_f), 32'(DEC_FLUSH));
    check("beq_link", bus.link_d, 32'h3010 + LINK_ADD);
    step(); check("beq_pc", bus.pc_f, 32'h3004);
    clear_dec();

    // Jump captured during a 3-cycle stall
    bus.stall_f = 1'b1; bus.pc_d = 32'h3020; bus.j_valid = 1'b1; bus.j_index = 26'h0000C40;
    #1;
    check("j_taken", 32'(bus.taken_d), 32'd1);
    check("j_stall_flush", 32'(bus.flush_f), 32'd0);
    step(); check("stall1", bus.pc_f, 32'h3004);
    clear_dec();
    step(); check("stall2", bus.pc_f, 32'h3004);
    step(); check("stall3", bus.pc_f, 32'h3004);
    bus.stall_f = 1'b0;
    #1;
    check("apply_flush", 32'(bus.flush_f), 32'(DEC_FLUSH));
    check("apply_taken", 32'(bus.taken_d), 32'd0);
    step(); check("j_pc", bus.pc_f, 32'h3100);
    check("pend_clr_flush", 32'(bus.flush_f), 32'd0);
    step(); check("pend_clr_seq", bus.pc_f, 32'h3104);

    // Pending jr discarded by exception while stalled
    bus.stall_f = 1'b1; bus.jr_valid = 1'b1; bus.jr_target = 32'h3400;
    step(); check("jr_pend_hold", bus.pc_f, 32'h3104);
    clear_dec();
    bus.exc_req = 1'b1;
    #1;
    check("exc_flush", 32'(bus.flush_f), 32'd1);
    step(); check("exc_pc", bus.pc_f, 32'h4180);
    clear_dec();
    bus.stall_f = 1'b0;
    #1;
    check("exc_nopend_flush", 32'(bus.flush_f), 32'd0);
    step(); check("exc_nopend_pc", bus.pc_f, 32'h4184);
    bus.eret_req = 1'b1; bus.epc = 32'h3024;
    #1;
    check("eret_flush", 32'(bus.flush_f), 32'd1);
    step(); check("eret_pc", bus.pc_f, 32'h3024);
    clear_dec();

    // jr beats j and a taken BNE in the same cycle
    bus.pc_d = 32'h3030; bus.jr_valid = 1'b1; bus.jr_target = 32'h3500;
    bus.j_valid = 1'b1; bus.j_index = 26'h0000100;
    bus.br_valid = 1'b1; bus.br_op = BR_BNE; bus.rs_val = 32'd1; bus.rt_val = 32'd2; bus.imm16 = 16'h0010;
    step(); check("prio_pc", bus.pc_f, 32'h3500);
    clear_dec();

    // BLTZ on most-negative value is taken
    bus.pc_d = 32'h3500; bus.br_valid = 1'b1; bus.br_op = BR_BLTZ;
    bus.rs_val = 32'h8000_0000; bus.imm16 = 16'h0004;
    #1;
    check("bltz_taken", 32'(bus.taken_d), 32'd1);
    step(); check("bltz_pc", bus.pc_f, 32'h3514);

    // BGTZ on zero is not taken
    bus.br_op = BR_BGTZ; bus.rs_val = 32'd0;
    #1;
    check("bgtz_taken", 32'(bus.taken_d), 32'd0);
    step(); check("bgtz_pc", bus.pc_f, 32'h3518);
    clear_dec();

    // Misaligned jr target is passed through unaligned
    bus.jr_valid = 1'b1; bus.jr_target = 32'h3002;
    step(); check("mis_pc", bus.pc_f, 32'h3002);
    check("mis_flag", 32'(bus.misalign_f), 32'd1);
    check("mis_pc4", bus.pc4_f, 32'h3006);

    // Wrap at the top of the address space
    bus.jr_target = 32'hFFFF_FFFC;
    step(); check("top_pc", bus.pc_f, 32'hFFFF_FFFC);
    check("top_pc4", bus.pc4_f, 32'h0000_0000);
    clear_dec();
    step(); check("wrap_pc", bus.pc_f, 32'h0000_0000);
    check("wrap_misal", 32'(bus.misalign_f), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
